empty_ptr_storage: RTL and testbench
====================================

// Module: empty_ptr_storage
// PURPOSE
//  Free-address pool for the hash-table data RAM. Feeds the insert stage: presents the next unused address plus a valid flag and pops it on ack.
//  Accepts addresses released by the delete stage. Self-initialises after reset with every data-RAM address. Addresses are reissued in FIFO order.
// PARAMETERS
//  A_WIDTH  TABLE_ADDR_WIDTH  data-RAM address width; DEPTH = 2**A_WIDTH entries
// PORTS
//  clk_i                 in   1            single clock
//  rst_n_i               in   1            reset, asynchronous, active-low
//  empty_addr_o          out  A_WIDTH      head free address, to insert stage
//  empty_addr_val_o      out  1            empty_addr_o valid (pool non-empty, init done)
//  empty_addr_rd_ack_i   in   1            pop head; single-cycle pulse
//  add_addr_i            in   A_WIDTH      released address, from delete stage
//  add_addr_val_i        in   1            push add_addr_i this cycle
//  init_done_o           out  1            initial fill complete, stays high until reset
//  used_cnt_o            out  A_WIDTH+1    allocated addresses = DEPTH - pool count (stat)
//  err_underflow_o       out  1            sticky: ack with val low, or ack during init (stat)
//  err_overflow_o        out  1            sticky: add with pool full, or add during init (stat)
// BEHAVIOUR
//  Reset: state INIT_S; init_cnt=0; pool empty; all outputs 0.
//  FSM INIT_S -> READY_S; no other transitions; reset from any state returns to INIT_S. Reset mid-init or mid-operation discards pool contents.
//  INIT_S: each cycle push init_cnt and increment it.
//   - Transition to READY_S after DEPTH pushes, i.e. the cycle after the push of DEPTH-1.
//   - DEPTH cycles total from reset release.
//   - ack and add ignored in INIT_S.
//  READY_S: init_done_o=1; empty_addr_val_o=1 iff pool count>0. First head = 0.
//  Stability: empty_addr_o and empty_addr_val_o change only on ack, or on add while the pool is empty. The insert stage holds the address over several cycles before acking.
//  Ack in cycle N (val=1):
//   - Pool count decrements.
//   - At N+1 the next FIFO entry is presented; val=0 if the pool is now empty.
//   - No bubble: full-rate back-to-back acks are legal.
//  Add in cycle N (count<DEPTH):
//   - Entry is appended.
//   - If the pool was empty, it is presented with val=1 at N+1.
//  Ack+add same cycle: both performed; count unchanged.
//   - With count==1, the added address becomes head at N+1 (write-to-head bypass).
//   - With count==DEPTH, the add is accepted because the ack frees a slot.
//  Ack with val=0: ignored. Add with count==DEPTH and no ack: dropped.
//  Pool count width A_WIDTH+1, range 0..DEPTH. Read/write pointers A_WIDTH bits, natural wrap.
//  No duplicate-free check; the delete stage guarantees each address is released once.
// CONFIGURATION
//  EMPTY_PTR_STAT_EN defined:
//   - used_cnt_o is registered and tracks DEPTH-count; reads DEPTH during init.
//   - err_underflow_o and err_overflow_o are sticky until reset.
//  Not defined: used_cnt_o, err_underflow_o, err_overflow_o tied to 0; no extra registers.
//  Ports are present in both builds.
// STRUCTURE
//  hash_table pkg: TABLE_ADDR_WIDTH (existing); add localparam-friendly typedef table_ptr_t = logic [TABLE_ADDR_WIDTH-1:0].
//  Sub-module empty_ptr_fifo contains:
//   - DEPTH x A_WIDTH registered-read RAM;
//   - show-ahead output register with prefetch;
//   - push/pop/count logic.
//  empty_ptr_storage keeps the init FSM, input muxing (init_cnt vs add_addr_i) and stat logic.
// TESTING (A_WIDTH=3, DEPTH=8)
//  1 Release reset, no traffic -> init_done_o high at cycle 8; val=1, addr=0; used_cnt_o=0.
//  2 Eight acks back-to-back -> addrs 0..7 one per cycle; val=0 after last; used_cnt_o=8. A ninth ack sets err_underflow_o.
//  3 Pool empty, add 5 at N -> addr=5, val=1 at N+1. Add 2 then ack -> head becomes 2.
//  4 Pool with 1 entry (7); ack+add 3 same cycle -> N+1 addr=3, val=1, count stays 1.
//  5 Pool full, add 4 alone -> dropped, err_overflow_o=1. Ack+add 4 -> accepted, count 8, 4 issued last.
//  6 Reset asserted mid-init at cycle 4 -> outputs 0 immediately; re-init presents 0..7 again.

Source files
------------

// File: rtl/empty_ptr_storage_pkg.sv
// ---------------------------------------------------------------------------
// empty_ptr_storage_pkg
//   Shared definitions for the hash-table free-address pool.
//   - TABLE_ADDR_WIDTH : data-RAM address width used by the hash table
//   - table_ptr_t      : data-RAM address type
//   - INIT_S / READY_S : pool FSM state encodings
// ---------------------------------------------------------------------------
package empty_ptr_storage_pkg;

    localparam int TABLE_ADDR_WIDTH = 8;

    typedef logic [TABLE_ADDR_WIDTH-1:0] table_ptr_t;

    localparam logic [0:0] INIT_S  = 1'b0;
    localparam logic [0:0] READY_S = 1'b1;

endpackage

// File: rtl/empty_ptr_fifo.sv
// ---------------------------------------------------------------------------
// empty_ptr_fifo
//   DEPTH x A_WIDTH FIFO with a registered-read RAM and a show-ahead head
//   register. The head register is loaded every cycle from the RAM location
//   the read pointer will point at next, so the head follows pops with no
//   bubble. The caller guarantees push only when not full (or full with pop)
//   and pop only when non-empty.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: append i_wdata at the tail
//   i_pop          : drop the current head
//   o_head, o_val  : current head entry and non-empty flag (registered)
//   o_cnt          : entry count, 0..DEPTH
// ---------------------------------------------------------------------------
module empty_ptr_fifo
    import empty_ptr_storage_pkg::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [A_WIDTH-1:0] i_wdata,
    input  logic               i_pop,
    output logic [A_WIDTH-1:0] o_head,
    output logic               o_val,
    output logic [A_WIDTH:0]   o_cnt
);

    localparam int DEPTH = 1 << A_WIDTH;

    logic [A_WIDTH-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_rd_ptr;
    logic [A_WIDTH:0]   r_cnt;
    logic [A_WIDTH-1:0] r_head;
    logic               r_val;

    logic [A_WIDTH-1:0] w_rd_ptr_nxt;
    logic [A_WIDTH:0]   w_cnt_nxt;
    logic               w_bypass;

    assign w_rd_ptr_nxt = i_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    // The only RAM slot that can be written in the same cycle it is fetched
    // is the one the head is about to move onto: pool empty, or one entry
    // left with a simultaneous pop. Forward the write data in that case.
    assign w_bypass = i_push && (r_wr_ptr == w_rd_ptr_nxt);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({i_push, i_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Storage array: no reset, contents are only meaningful under the count.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_head   <= '0;
            r_val    <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_val    <= (w_cnt_nxt != '0);
            // Head slot only changes on pop or on a write into it, so the
            // presented address is stable between those events.
            r_head   <= w_bypass ? i_wdata : r_mem[w_rd_ptr_nxt];
        end
    end

    assign o_head = r_head;
    assign o_val  = r_val;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/empty_ptr_storage.sv
// ---------------------------------------------------------------------------
// empty_ptr_storage
//   Free-address pool for the hash-table data RAM. After reset it fills
//   itself with every address 0..DEPTH-1, then presents the head free
//   address to the insert stage (popped on ack) and accepts addresses
//   released by the delete stage. Addresses are reissued in FIFO order.
//   Optional statistics build: define EMPTY_PTR_STAT_EN to get a registered
//   used-address count and sticky underflow/overflow flags; otherwise those
//   ports read 0.
// Ports
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   empty_addr_o/_val_o   : head free address and its valid flag
//   empty_addr_rd_ack_i   : pop the head
//   add_addr_i/_val_i     : push a released address
//   init_done_o           : initial fill complete
//   used_cnt_o            : DEPTH - pool count (stat build)
//   err_underflow_o       : sticky, ack with nothing valid or during init
//   err_overflow_o        : sticky, add dropped (full) or add during init
// ---------------------------------------------------------------------------
module empty_ptr_storage
    import empty_ptr_storage_pkg::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    output logic [A_WIDTH-1:0] empty_addr_o,
    output logic               empty_addr_val_o,
    input  logic               empty_addr_rd_ack_i,
    input  logic [A_WIDTH-1:0] add_addr_i,
    input  logic               add_addr_val_i,
    output logic               init_done_o,
    output logic [A_WIDTH:0]   used_cnt_o,
    output logic               err_underflow_o,
    output logic               err_overflow_o
);

    localparam logic [A_WIDTH:0] CNT_FULL = {1'b1, {A_WIDTH{1'b0}}};

    logic [0:0]         r_state;
    logic [A_WIDTH-1:0] r_init_cnt;

    logic               w_ready;
    logic               w_init_last;
    logic               w_pop;
    logic               w_add_acc;
    logic               w_push;
    logic [A_WIDTH-1:0] w_wdata;
    logic [A_WIDTH-1:0] w_fifo_head;
    logic               w_fifo_val;
    logic [A_WIDTH:0]   w_fifo_cnt;

    assign w_ready     = (r_state == READY_S);
    assign w_init_last = !w_ready && (r_init_cnt == {A_WIDTH{1'b1}});

    // Traffic from the neighbouring stages is ignored until the fill is done.
    assign w_pop     = w_ready && empty_addr_rd_ack_i && w_fifo_val;
    // A full pool still takes an add when an ack frees a slot the same cycle.
    assign w_add_acc = w_ready && add_addr_val_i &&
                       ((w_fifo_cnt != CNT_FULL) || w_pop);
    assign w_push    = !w_ready || w_add_acc;
    assign w_wdata   = w_ready ? add_addr_i : r_init_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= INIT_S;
            r_init_cnt <= '0;
        end else if (!w_ready) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (w_init_last) begin
                r_state <= READY_S;
            end
        end
    end

    empty_ptr_fifo #(
        .A_WIDTH (A_WIDTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_val   (w_fifo_val),
        .o_cnt   (w_fifo_cnt)
    );

    // The FIFO already holds entries during the fill; hide them until ready.
    assign empty_addr_o     = w_fifo_head;
    assign empty_addr_val_o = w_ready && w_fifo_val;
    assign init_done_o      = w_ready;

`ifdef EMPTY_PTR_STAT_EN
    logic [A_WIDTH:0] r_used;
    logic             r_err_uf;
    logic             r_err_of;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_used   <= '0;
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
        end else begin
            if (!w_ready) begin
                // Nothing is handed out yet; the last fill push empties usage.
                r_used <= w_init_last ? '0 : CNT_FULL;
            end else begin
                case ({w_pop, w_add_acc})
                    2'b10:   r_used <= r_used + 1'b1;
                    2'b01:   r_used <= r_used - 1'b1;
                    default: r_used <= r_used;
                endcase
            end
            if (empty_addr_rd_ack_i && !(w_ready && w_fifo_val)) begin
                r_err_uf <= 1'b1;
            end
            if (add_addr_val_i && !w_add_acc) begin
                r_err_of <= 1'b1;
            end
        end
    end

    assign used_cnt_o      = r_used;
    assign err_underflow_o = r_err_uf;
    assign err_overflow_o  = r_err_of;
`else
    assign used_cnt_o      = '0;
    assign err_underflow_o = 1'b0;
    assign err_overflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_empty_ptr_storage.sv
module tb_empty_ptr_storage;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef EMPTY_PTR_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          val;
    logic          ack;
    logic [AW-1:0] add_addr;
    logic          add_val;
    logic          init_done;
    logic [AW:0]   used;
    logic          err_uf;
    logic          err_of;

    empty_ptr_storage #(.A_WIDTH(AW)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .empty_addr_o        (addr),
        .empty_addr_val_o    (val),
        .empty_addr_rd_ack_i (ack),
        .add_addr_i          (add_addr),
        .add_addr_val_i      (add_val),
        .init_done_o         (init_done),
        .used_cnt_o          (used),
        .err_underflow_o     (err_uf),
        .err_overflow_o      (err_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: the pool is a plain queue of free addresses.
    int q[$];
    bit m_ready;
    int m_idx;
    bit m_uf;
    bit m_of;

    task automatic model_reset();
        q.delete();
        m_ready = 0;
        m_idx   = 0;
        m_uf    = 0;
        m_of    = 0;
    endtask

    task automatic model_edge(input bit a, input bit d, input int da);
        bit popped;
        if (!m_ready) begin
            if (a) m_uf = 1;
            if (d) m_of = 1;
            q.push_back(m_idx);
            m_idx++;
            if (m_idx == DEPTH) m_ready = 1;
        end else begin
            popped = 0;
            if (a) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    popped = 1;
                end else m_uf = 1;
            end
            if (d) begin
                if (q.size() < DEPTH) q.push_back(da);
                else m_of = 1;
            end
            if (popped && d && q.size() > DEPTH) m_of = 1;
        end
    endtask

    task automatic check_all(input string ph);
        int exp_used;
        exp_used = m_ready ? DEPTH - q.size() : (m_idx > 0 ? DEPTH : 0);
        chk({ph, " init_done"}, init_done, m_ready);
        chk({ph, " val"}, val, (m_ready && q.size() > 0) ? 1 : 0);
        if (m_ready && q.size() > 0) chk({ph, " addr"}, addr, q[0]);
        chk({ph, " used"}, used, STAT ? exp_used : 0);
        chk({ph, " err_uf"}, err_uf, STAT ? m_uf : 0);
        chk({ph, " err_of"}, err_of, STAT ? m_of : 0);
    endtask

    // Inputs are applied just after an edge and sampled at the next one.
    task automatic step(input string ph, input bit a, input bit d, input int da);
        ack      = a;
        add_val  = d;
        add_addr = AW'(da);
        @(posedge clk);
        model_edge(a, d, da);
        #1;
        ack     = 1'b0;
        add_val = 1'b0;
        check_all(ph);
    endtask

    task automatic check_reset_outputs(input string ph);
        chk({ph, " rst addr"}, addr, 0);
        chk({ph, " rst val"}, val, 0);
        chk({ph, " rst init_done"}, init_done, 0);
        chk({ph, " rst used"}, used, 0);
        chk({ph, " rst err_uf"}, err_uf, 0);
        chk({ph, " rst err_of"}, err_of, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ack      = 1'b0;
        add_val  = 1'b0;
        add_addr = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("t0");
        rst_n = 1'b1;

        // 1: self-initialisation, ready after DEPTH edges with head 0
        for (int i = 0; i < DEPTH; i++) step("t1", 0, 0, 0);
        chk("t1 ready_addr0", addr, 0);
        chk("t1 ready_val", val, 1);

        // 2: drain at full rate, then one ack too many
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2 seq", addr, i);
            step("t2", 1, 0, 0);
        end
        chk("t2 empty_val", val, 0);
        step("t2 extra", 1, 0, 0);

        // 3: add into empty pool, add another, ack -> second becomes head
        step("t3 add5", 0, 1, 5);
        chk("t3 head5", addr, 5);
        step("t3 add2", 0, 1, 2);
        step("t3 ack", 1, 0, 0);
        chk("t3 head2", addr, 2);

        // 4: single entry (7), ack+add 3 -> bypass to head
        step("t4 swap7", 1, 1, 7);
        chk("t4 head7", addr, 7);
        step("t4 swap3", 1, 1, 3);
        chk("t4 head3", addr, 3);
        chk("t4 val", val, 1);

        // 5: fill, add when full is dropped, ack+add when full accepted
        for (int i = 0; i < DEPTH - 1; i++) step("t5 fill", 0, 1, i);
        step("t5 drop", 0, 1, 4);
        step("t5 swap", 1, 1, 4);
        for (int i = 0; i < DEPTH; i++) step("t5 drain", 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step("rnd", ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 45),
                 int'($urandom_range(0, DEPTH - 1)));
        end

        // 6: reset mid-init, outputs clear immediately, re-init from 0
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("t6a");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("t6 init", $urandom_range(0, 1), 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("t6b");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step("t6 reinit", 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t6 seq", addr, i);
            step("t6 drain", 1, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
